// File: rtl/nubus_pkg.sv
// Shared NuBus slave definitions: transfer-mode codes, status codes,
// responder FSM states and the transfer-mode to byte-enable mapping.
package nubus_pkg;

  // Transfer mode as raw line levels {/TM1,/TM0,/AD1,/AD0}
  localparam logic [3:0] TMADN_WR_BYTE_3 = 4'b0000;
  localparam logic [3:0] TMADN_WR_BYTE_2 = 4'b0001;
  localparam logic [3:0] TMADN_WR_BYTE_1 = 4'b0010;
  localparam logic [3:0] TMADN_WR_BYTE_0 = 4'b0011;
  localparam logic [3:0] TMADN_WR_HALF_1 = 4'b0100;
  localparam logic [3:0] TMADN_WR_BLOCK  = 4'b0101;
  localparam logic [3:0] TMADN_WR_HALF_0 = 4'b0110;
  localparam logic [3:0] TMADN_WR_WORD   = 4'b0111;
  localparam logic [3:0] TMADN_RD_BYTE_3 = 4'b1000;
  localparam logic [3:0] TMADN_RD_BYTE_2 = 4'b1001;
  localparam logic [3:0] TMADN_RD_BYTE_1 = 4'b1010;
  localparam logic [3:0] TMADN_RD_BYTE_0 = 4'b1011;
  localparam logic [3:0] TMADN_RD_HALF_1 = 4'b1100;
  localparam logic [3:0] TMADN_RD_BLOCK  = 4'b1101;
  localparam logic [3:0] TMADN_RD_HALF_0 = 4'b1110;
  localparam logic [3:0] TMADN_RD_WORD   = 4'b1111;

  localparam logic [1:0] TMN_COMPLETE        = 2'b11;
  localparam logic [1:0] TMN_ERROR           = 2'b10;
  localparam logic [1:0] TMN_TIMEOUT         = 2'b01;
  localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_ACCESS,
    ST_ACK,
    ST_TURN
  } nubus_state_t;

  // Returns {we, be[3:0], is_block}; /TM1 high means read
  function automatic logic [5:0] tmad_to_be(input logic [3:0] tmadn);
    logic       we;
    logic [3:0] be;
    logic       blk;
    we  = ~tmadn[3];
    blk = 1'b0;
    case (tmadn[2:0])
      3'b000:  be = 4'b1000;
      3'b001:  be = 4'b0100;
      3'b010:  be = 4'b0010;
      3'b011:  be = 4'b0001;
      3'b100:  be = 4'b1100;
      3'b110:  be = 4'b0011;
      3'b111:  be = 4'b1111;
      default: begin
        be  = 4'b0000;
        blk = 1'b1;
      end
    endcase
    return {we, be, blk};
  endfunction

endpackage

// File: rtl/nubus_tm_decode.sv
// Combinational transfer-mode decoder wrapping tmad_to_be.
module nubus_tm_decode
  import nubus_pkg::*;
(
  input  logic [3:0] tmadn,
  output logic       we,
  output logic [3:0] be,
  output logic       is_block
);

  assign {we, be, is_block} = tmad_to_be(tmadn);

endmodule

// File: rtl/nubus_slave_resp.sv
// NuBus slot-space responder: decodes START cycles, issues one local memory
// request per transfer and answers with /ACK, status and read data.
module nubus_slave_resp
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CLOCKS = 255,
  parameter int ENABLE_BLOCK   = 0
) (
  input  logic        clk_3v3_n,
  input  logic        reset_3v3_n,
  input  logic [3:0]  id_3v3_n,
  input  logic        start_3v3_n,
  input  logic        ack_3v3_n_i,
  input  logic [1:0]  tm_n_i,
  input  logic [31:0] ad_n_i,
  output logic [31:0] ad_n_o,
  output logic        ad_oe,
  output logic [1:0]  tm_n_o,
  output logic        ack_n_o,
  output logic        ctl_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CLOCKS - 1);

  if (ENABLE_BLOCK != 0) begin : g_block_check
    $error("nubus_slave_resp: block transfers are not implemented, ENABLE_BLOCK must be 0");
  end

  logic        start_n_q;
  logic        ack_n_q;
  logic [1:0]  tm_n_q;
  logic [31:0] ad_n_q;

  // Bus lines are sampled on the falling edge of /CLK
  always_ff @(negedge clk_3v3_n or negedge reset_3v3_n) begin
    if (!reset_3v3_n) begin
      start_n_q <= 1'b1;
      ack_n_q   <= 1'b1;
      tm_n_q    <= 2'b11;
      ad_n_q    <= '1;
    end else begin
      start_n_q <= start_3v3_n;
      ack_n_q   <= ack_3v3_n_i;
      tm_n_q    <= tm_n_i;
      ad_n_q    <= ad_n_i;
    end
  end

  logic [7:0] slot_space;
  logic       start_hit;
  logic [3:0] tmadn;
  logic       dec_we;
  logic [3:0] dec_be;
  logic       dec_block;

  // START with /ACK low is an attention cycle, not a transfer
  assign slot_space = {4'hF, ~id_3v3_n};
  assign start_hit  = ~start_n_q & ack_n_q & (~ad_n_q[31:24] == slot_space);
  assign tmadn      = {tm_n_q, ad_n_q[1:0]};

  nubus_tm_decode u_tm_decode (
    .tmadn    (tmadn),
    .we       (dec_we),
    .be       (dec_be),
    .is_block (dec_block)
  );

  nubus_state_t state;
  logic [7:0]   wait_cnt;

  always_ff @(posedge clk_3v3_n or negedge reset_3v3_n) begin
    if (!reset_3v3_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      ad_oe     <= 1'b0;
      ctl_oe    <= 1'b0;
      ack_n_o   <= 1'b1;
      tm_n_o    <= TMN_COMPLETE;
      ad_n_o    <= '1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_hit) begin
            mem_addr <= ~ad_n_q[23:2];
            mem_be   <= dec_be;
            mem_we   <= dec_we;
            if (dec_block) begin
              ctl_oe  <= 1'b1;
              ack_n_o <= 1'b0;
              tm_n_o  <= TMN_ERROR;
              state   <= ST_ACK;
            end else if (dec_we) begin
              state <= ST_WDATA;
            end else begin
              mem_req  <= 1'b1;
              wait_cnt <= '0;
              state    <= ST_ACCESS;
            end
          end
        end
        ST_WDATA: begin
          mem_wdata <= ~ad_n_q;
          mem_req   <= 1'b1;
          wait_cnt  <= '0;
          state     <= ST_ACCESS;
        end
        // mem_req is dropped on exit either way, so a late mem_ack cannot retrigger
        ST_ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            ad_n_o  <= ~mem_rdata;
            ctl_oe  <= 1'b1;
            ack_n_o <= 1'b0;
            tm_n_o  <= mem_err ? TMN_ERROR : TMN_COMPLETE;
            ad_oe   <= ~mem_we & ~mem_err;
            state   <= ST_ACK;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_req <= 1'b0;
            ctl_oe  <= 1'b1;
            ack_n_o <= 1'b0;
            tm_n_o  <= TMN_TRY_AGAIN_LATER;
            ad_oe   <= 1'b0;
            state   <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ACK: begin
          ctl_oe  <= 1'b0;
          ack_n_o <= 1'b1;
          tm_n_o  <= TMN_COMPLETE;
          ad_oe   <= 1'b0;
          ad_n_o  <= '1;
          state   <= ST_TURN;
        end
        ST_TURN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
